sobel_mag: RTL and testbench
============================

// Module: sobel_mag
// PURPOSE
//  Gradient-magnitude stage directly downstream of conv2d in the sobel pipeline.
//  Takes the signed gx/gy pair per pixel and computes |gx|+|gy|, shifted by SHIFT_P and saturated to WIDTH_P bits.
//  Zeroes window warm-up border pixels (col<2 or row<2) and flags end-of-line.
//  Output feeds the 24-bit replicate/unpack path toward the UART TX.
// PARAMETERS
//  WIDTH_P    8    pixel width; gx/gy are 2*WIDTH_P signed
//  LINE_W_P   640  pixels per line
//  FRAME_H_P  480  lines per frame
//  SHIFT_P    2    right shift applied to |gx|+|gy| before saturation
//  THRESH_P   64   binarisation threshold (used only with SOBEL_MAG_THRESH_EN)
// PORTS
//  clk_i    in   1          core clock
//  rstn_i   in   1          asynchronous active-low reset
//  valid_i  in   1          gx_i/gy_i valid
//  ready_o  out  1          stage can accept input this cycle
//  gx_i     in   2*WIDTH_P  signed horizontal gradient
//  gy_i     in   2*WIDTH_P  signed vertical gradient
//  valid_o  out  1          mag_o valid
//  ready_i  in   1          downstream accepts mag_o
//  mag_o    out  WIDTH_P    gradient magnitude
//  eol_o    out  1          qualifies mag_o: last pixel of a line
// BEHAVIOUR
//  - Reset (async assert, sync release): valid_o=0, mag_o=0, eol_o=0, all stage valids=0, col=row=0.
//  - Handshakes: transfer on valid&ready; valid_o/mag_o/eol_o held stable while valid_o&~ready_i.
//  - Two register stages (S1, S2); latency 2 cycles; throughput 1 pixel/cycle with ready_i high.
//  - S2 advances when ~s2_valid | ready_i. S1 advances when ~s1_valid | S2 advances.
//  - ready_o = ~s1_valid | S2 advance. This is a combinational path from ready_i and has no bubble.
//  - S1 (on input transfer):
//    - abs_x=|gx_i|, abs_y=|gy_i| as unsigned 2*WIDTH_P bits; -2^(2W-1) maps to 2^(2W-1), with no overflow.
//    - Captures border = (col<2)|(row<2) and eol = (col==LINE_W_P-1).
//  - Position counters advance on input transfer only:
//    - col increments and wraps LINE_W_P-1 -> 0.
//    - On col wrap, row increments and wraps FRAME_H_P-1 -> 0.
//  - S2:
//    - sum = abs_x+abs_y, 2*WIDTH_P+1 bits; s = sum>>SHIFT_P.
//    - mag = (s > 2^WIDTH_P-1) ? all-ones : s[WIDTH_P-1:0].
//    - border forces mag=0; eol passes through unchanged.
//  - Counter update is gated only by the input transfer. Simultaneous input transfer and output stall is legal
//    while S1 is free; S1 never overwrites unconsumed data.
//  - Reset mid-frame: in-flight pixels are discarded; the next accepted pixel is col 0, row 0.
// CONFIGURATION
//  - SOBEL_MAG_THRESH_EN defined: after saturation and border masking, mag_o = (mag>=THRESH_P) ? all-ones : 0.
//  - Not defined: mag_o carries the saturated magnitude. THRESH_P is ignored. Latency is 2 in both builds.
// STRUCTURE
//  - sobel_pkg holds:
//    - typedef pix_t (logic [WIDTH_P-1:0]).
//    - typedef grad_t (logic signed [2*WIDTH_P-1:0]).
//    - localparam BORDER_C=2 (window warm-up columns/rows).
//  - Sub-module pix_pos: col/row counter with advance input and col/row/eol/border outputs.
//    It is reusable by other window stages.
// TESTING
//  1 Reset release, no input -> valid_o=0, mag_o=0, ready_o=1; first pixel at (2,2), gx=40, gy=-24, SHIFT_P=2
//    -> mag_o=16 two cycles later.
//  2 gx=-32768, gy=-32768 (W=8) -> sum=65536, >>2 = 16384 -> mag_o=255; gx=gy=0 -> mag_o=0.
//  3 Stream a 640x480 frame with ready_i=1 -> 1 output per cycle; pixels with col<2 or row<2 yield 0;
//    eol_o high exactly on every 640th output; the 307201st pixel is treated as (0,0).
//  4 Random ready_i (50%) with continuous valid_i -> no loss/duplication versus a reference model;
//    outputs stable while stalled; ready_o never low when S1 empty.
//  5 Assert rstn_i mid-line at col 100 with both stages full -> valid_o drops immediately;
//    after release the next pixel is border (mag_o=0) at col 0, row 0.
//  6 With SOBEL_MAG_THRESH_EN, THRESH_P=64: (2,2) pixel gx=200, gy=52 (mag 63) -> 0;
//    gx=200, gy=56 (mag 64) -> 255.

Source files
------------

// File: rtl/sobel_mag_pkg.sv
// Shared types and constants for the sobel gradient-magnitude stage and its window helpers.
// Default pixel width matches the sobel_mag WIDTH_P default.
package sobel_pkg;

  localparam int PIX_W_C  = 8;
  localparam int BORDER_C = 2;

  typedef logic [PIX_W_C-1:0]          pix_t;
  typedef logic signed [2*PIX_W_C-1:0] grad_t;

endpackage

// File: rtl/sobel_mag_if.sv
// Stream bundle for sobel_mag: gradient pair in, magnitude/eol out, valid/ready on both sides.
// slave is the stage's own view, master is the driving/consuming environment.
interface sobel_mag_if #(
  parameter int WIDTH_P = 8
);

  logic                          valid_i;
  logic                          ready_o;
  logic signed [2*WIDTH_P-1:0]   gx_i;
  logic signed [2*WIDTH_P-1:0]   gy_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [WIDTH_P-1:0]            mag_o;
  logic                          eol_o;

  modport slave (
    input  valid_i, gx_i, gy_i, ready_i,
    output ready_o, valid_o, mag_o, eol_o
  );

  modport master (
    output valid_i, gx_i, gy_i, ready_i,
    input  ready_o, valid_o, mag_o, eol_o
  );

endinterface

// File: rtl/sobel_mag_pix_pos.sv
// Raster position tracker for window stages: col/row of the next pixel, advancing once per accepted pixel.
// eol and border describe the pixel at the current position.
module pix_pos
  import sobel_pkg::*;
#(
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480,
  localparam int COL_W    = $clog2(LINE_W_P),
  localparam int ROW_W    = $clog2(FRAME_H_P)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             eol,
  output logic             border
);

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_nxt_s;
  logic [ROW_W-1:0] row_nxt_s;

  // Next position: column wraps at end of line and carries into the row, which wraps at end of frame.
  always_comb begin
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    if (advance) begin
      if (col_r == COL_W'(LINE_W_P - 1)) begin
        col_nxt_s = {COL_W{1'b0}};
        if (row_r == ROW_W'(FRAME_H_P - 1)) begin
          row_nxt_s = {ROW_W{1'b0}};
        end else begin
          row_nxt_s = row_r + ROW_W'(1);
        end
      end else begin
        col_nxt_s = col_r + COL_W'(1);
        row_nxt_s = row_r;
      end
    end else begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  assign col    = col_r;
  assign row    = row_r;
  assign eol    = (col_r == COL_W'(LINE_W_P - 1));
  assign border = (col_r < COL_W'(BORDER_C)) || (row_r < ROW_W'(BORDER_C));

endmodule

// File: rtl/sobel_mag.sv
// Sobel gradient magnitude: |gx|+|gy| >> SHIFT_P, saturated, border-masked, two register stages.
// Optional build macro SOBEL_MAG_THRESH_EN binarises the result against THRESH_P.
module sobel_mag
  import sobel_pkg::*;
#(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480,
  parameter int SHIFT_P   = 2,
  parameter int THRESH_P  = 64
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  sobel_mag_if.slave bus
);

  localparam int GW_C    = 2 * WIDTH_P;
  localparam int COL_W_C = $clog2(LINE_W_P);
  localparam int ROW_W_C = $clog2(FRAME_H_P);
  localparam logic [GW_C:0] MAX_C = {{(GW_C + 1 - WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

  // Two's-complement magnitude; the most negative value maps to its unsigned magnitude without overflow.
  function automatic logic [GW_C-1:0] abs_f(input logic [GW_C-1:0] v);
    logic [GW_C-1:0] r;
    if (v[GW_C-1]) begin
      r = ~v + GW_C'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic               s1_valid_r;
  logic [GW_C-1:0]    s1_abs_x_r;
  logic [GW_C-1:0]    s1_abs_y_r;
  logic               s1_border_r;
  logic               s1_eol_r;
  logic               s2_valid_r;
  logic [WIDTH_P-1:0] s2_mag_r;
  logic               s2_eol_r;

  logic               s2_adv_s;
  logic               s1_adv_s;
  logic               in_xfer_s;
  logic               pos_eol_s;
  logic               pos_border_s;
  logic [COL_W_C-1:0] col_unused_s;
  logic [ROW_W_C-1:0] row_unused_s;
  logic [31:0]        thresh_unused_s;
  logic [GW_C:0]      sum_s;
  logic [GW_C:0]      shift_s;
  logic [WIDTH_P-1:0] sat_s;
  logic [WIDTH_P-1:0] masked_s;
  logic [WIDTH_P-1:0] mag_s;

  // Skid-free pipeline: each stage may load whenever the stage after it moves.
  assign s2_adv_s  = ~s2_valid_r | bus.ready_i;
  assign s1_adv_s  = ~s1_valid_r | s2_adv_s;
  assign in_xfer_s = bus.valid_i & s1_adv_s;

  assign thresh_unused_s = 32'(THRESH_P);

  pix_pos #(
    .LINE_W_P  (LINE_W_P),
    .FRAME_H_P (FRAME_H_P)
  ) u_pix_pos (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .advance (in_xfer_s),
    .col     (col_unused_s),
    .row     (row_unused_s),
    .eol     (pos_eol_s),
    .border  (pos_border_s)
  );

  // S1: capture absolute gradients and the pixel's position flags on input transfer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_r  <= 1'b0;
      s1_abs_x_r  <= {GW_C{1'b0}};
      s1_abs_y_r  <= {GW_C{1'b0}};
      s1_border_r <= 1'b0;
      s1_eol_r    <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.valid_i;
      if (bus.valid_i) begin
        s1_abs_x_r  <= abs_f(bus.gx_i);
        s1_abs_y_r  <= abs_f(bus.gy_i);
        s1_border_r <= pos_border_s;
        s1_eol_r    <= pos_eol_s;
      end
    end
  end

  // Magnitude: sum, shift, saturate, mask border, then optional binarisation.
  always_comb begin
    sum_s   = {1'b0, s1_abs_x_r} + {1'b0, s1_abs_y_r};
    shift_s = sum_s >> SHIFT_P;
    if (shift_s > MAX_C) begin
      sat_s = {WIDTH_P{1'b1}};
    end else begin
      sat_s = shift_s[WIDTH_P-1:0];
    end
    if (s1_border_r) begin
      masked_s = {WIDTH_P{1'b0}};
    end else begin
      masked_s = sat_s;
    end
`ifdef SOBEL_MAG_THRESH_EN
    if (masked_s >= WIDTH_P'(THRESH_P)) begin
      mag_s = {WIDTH_P{1'b1}};
    end else begin
      mag_s = {WIDTH_P{1'b0}};
    end
`else
    mag_s = masked_s;
`endif
  end

  // S2: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_valid_r <= 1'b0;
      s2_mag_r   <= {WIDTH_P{1'b0}};
      s2_eol_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_mag_r <= mag_s;
        s2_eol_r <= s1_eol_r;
      end
    end
  end

  assign bus.ready_o = s1_adv_s;
  assign bus.valid_o = s2_valid_r;
  assign bus.mag_o   = s2_mag_r;
  assign bus.eol_o   = s2_eol_r;

endmodule

// File: tb/tb_sobel_mag.sv
// Self-checking bench for sobel_mag: behavioural magnitude/position model, randomised gradients and back-pressure.
module tb_sobel_mag;
  import sobel_pkg::*;

  localparam int W  = 8;
  localparam int LW = 20;
  localparam int FH = 8;
  localparam int SH = 2;
  localparam int TH = 64;

`ifdef SOBEL_MAG_THRESH_EN
  localparam int E16 = 0;
  localparam int E255 = 255;
  localparam int E63 = 0;
  localparam int E64 = 255;
`else
  localparam int E16 = 16;
  localparam int E255 = 255;
  localparam int E63 = 63;
  localparam int E64 = 64;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sobel_mag_if #(.WIDTH_P(W)) bus ();

  sobel_mag #(
    .WIDTH_P   (W),
    .LINE_W_P  (LW),
    .FRAME_H_P (FH),
    .SHIFT_P   (SH),
    .THRESH_P  (TH)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int pass_cnt = 0;
  int chk_cnt = 0;
  int exp_mag_q[$];
  bit exp_eol_q[$];
  int idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_mag(input int gx, input int gy, input bit border);
    int s;
    s = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> SH;
    if (s > (1 << W) - 1) s = (1 << W) - 1;
    if (border) s = 0;
`ifdef SOBEL_MAG_THRESH_EN
    s = (s >= TH) ? (1 << W) - 1 : 0;
`endif
    return s;
  endfunction

  function automatic grad_t rand_grad();
    grad_t g;
    case ($urandom_range(0, 7))
      0: g = 16'sh8000;
      1: g = 16'sh7fff;
      2: g = grad_t'($urandom_range(0, 600)) - 16'sd300;
      default: g = grad_t'($urandom);
    endcase
    return g;
  endfunction

  // Compare process: scoreboard of accepted pixels against every consumed output.
  initial begin : compare
    bit prev_stall;
    int prev_mag;
    bit prev_eol;
    int m;
    bit e;
    int c;
    int r;
    prev_stall = 1'b0;
    prev_mag = 0;
    prev_eol = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_mag_q.delete();
        exp_eol_q.delete();
        idx = 0;
        prev_stall = 1'b0;
        chk("rst_valid_o", int'(bus.valid_o), 0);
      end else begin
        if (!bus.valid_o) chk("ready_when_idle", int'(bus.ready_o), 1);
        if (prev_stall) begin
          chk("stall_valid", int'(bus.valid_o), 1);
          chk("stall_mag", int'(bus.mag_o), prev_mag);
          chk("stall_eol", int'(bus.eol_o), int'(prev_eol));
        end
        if (bus.valid_o && bus.ready_i) begin
          if (exp_mag_q.size() == 0) begin
            chk("unexpected_output", exp_mag_q.size(), 1);
          end else begin
            m = exp_mag_q.pop_front();
            e = exp_eol_q.pop_front();
            chk("mag", int'(bus.mag_o), m);
            chk("eol", int'(bus.eol_o), int'(e));
          end
        end
        if (bus.valid_i && bus.ready_o) begin
          c = idx % LW;
          r = (idx / LW) % FH;
          exp_mag_q.push_back(model_mag(int'(bus.gx_i), int'(bus.gy_i), (c < 2) || (r < 2)));
          exp_eol_q.push_back(c == LW - 1);
          idx++;
        end
        prev_stall = bus.valid_o && !bus.ready_i;
        prev_mag = int'(bus.mag_o);
        prev_eol = bus.eol_o;
      end
    end
  end

  task automatic drive_px(input grad_t gx, input grad_t gy);
    bus.valid_i = 1'b1;
    bus.gx_i = gx;
    bus.gy_i = gy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input grad_t gx, input grad_t gy, input int exp, input string name);
    bus.valid_i = 1'b1;
    bus.gx_i = gx;
    bus.gy_i = gy;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_valid"}, int'(bus.valid_o), 1);
    chk(name, int'(bus.mag_o), exp);
    chk({name, "_eol"}, int'(bus.eol_o), 0);
  endtask

  task automatic run_stream(input int n, input bit rand_ready);
    bit acc;
    bus.valid_i = 1'b1;
    bus.gx_i = rand_grad();
    bus.gy_i = rand_grad();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc = bus.valid_i && bus.ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.gx_i = rand_grad();
        bus.gy_i = rand_grad();
      end
      bus.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.ready_i = 1'b1;
  endtask

  initial begin : stimulus
    bus.valid_i = 1'b0;
    bus.gx_i = 16'sd0;
    bus.gy_i = 16'sd0;
    bus.ready_i = 1'b1;

    chk("model_40_m24", model_mag(40, -24, 1'b0), E16);
    chk("model_min_min", model_mag(-32768, -32768, 1'b0), E255);
    chk("model_200_52", model_mag(200, 52, 1'b0), E63);
    chk("model_200_56", model_mag(200, 56, 1'b0), E64);
    chk("model_border", model_mag(1000, 1000, 1'b1), 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_valid_o", int'(bus.valid_o), 0);
    chk("reset_mag_o", int'(bus.mag_o), 0);
    chk("reset_ready_o", int'(bus.ready_o), 1);

    // Fill up to (2,2), then directed pixels at cols 2..6 of row 2.
    for (int i = 0; i < 2 * LW + 2; i++) drive_px(rand_grad(), rand_grad());
    send_one(16'sd40, -16'sd24, E16, "px_40_m24");
    send_one(16'sh8000, 16'sh8000, E255, "px_min_min");
    send_one(16'sd0, 16'sd0, 0, "px_zero");
    send_one(16'sd200, 16'sd52, E63, "px_200_52");
    send_one(16'sd200, 16'sd56, E64, "px_200_56");

    run_stream(2 * LW * FH, 1'b0);
    run_stream(700, 1'b1);

    // Mid-line reset with both stages full.
    bus.ready_i = 1'b1;
    for (int g = 0; g < 2 * LW; g++) begin
      if (idx % LW == 10) break;
      drive_px(rand_grad(), rand_grad());
    end
    bus.ready_i = 1'b0;
    repeat (3) drive_px(rand_grad(), rand_grad());
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_valid_o", int'(bus.valid_o), 0);
    chk("midrst_ready_o", int'(bus.ready_o), 1);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_one(16'sh0700, 16'sh0700, 0, "post_rst_border");

    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", exp_mag_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
